// File: rtl/calc_ctrl.sv
// Sequencing controller for the grid calculator: builds operands A/B from cursor
// presses, latches the operation and runs the start/done handshake with the ALU.
module calc_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press,
  input  logic [4:0]       val,
  input  logic             mode_dec,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       stage
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_WAIT = 2'd2, S_RES = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] disp_q, disp_d;

  logic       is_digit, is_op, is_exe, is_ce, is_clr, clear_all;
  logic [2:0] key_op;
  logic [WIDTH-1:0] digit_ext;

  function automatic logic [WIDTH-1:0] accum(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] d,
                                             input logic dec);
    if (dec) return (x * WIDTH'(10)) + d;
    return {x[WIDTH-5:0], d[3:0]};
  endfunction

  // Decimal mode silently drops hex-only digits A-F.
  assign is_digit  = press && !val[4] && !(mode_dec && (val[3:0] > 4'd9));
  assign is_exe    = press && (val == 5'h13);
  assign is_ce     = press && (val == 5'h16);
  assign is_clr    = press && (val == 5'h17);
  assign digit_ext = {{(WIDTH-4){1'b0}}, val[3:0]};

  always_comb begin
    is_op  = press;
    key_op = 3'd0;
    case (val)
      5'h10:   key_op = 3'd0;
      5'h14:   key_op = 3'd1;
      5'h11:   key_op = 3'd2;
      5'h12:   key_op = 3'd3;
      5'h15:   key_op = 3'd4;
      default: is_op  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    acnt_d    = acnt_q;
    bcnt_d    = bcnt_q;
    op_d      = op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    start_d   = 1'b0;
    clear_all = 1'b0;
    disp_d    = disp_q;

    case (state_q)
      S_A: begin
        if (is_digit) begin
          if (acnt_q != FULL_CNT) begin
            a_d    = accum(a_q, digit_ext, mode_dec);
            acnt_d = acnt_q + 1'b1;
          end
        end else if (is_op) begin
          op_d    = key_op;
          b_d     = '0;
          bcnt_d  = '0;
          state_d = S_B;
        end else if (is_ce) begin
          a_d    = '0;
          acnt_d = '0;
        end else if (is_clr) begin
          clear_all = 1'b1;
        end
      end
      S_B: begin
        if (is_digit) begin
          if (bcnt_q != FULL_CNT) begin
            b_d    = accum(b_q, digit_ext, mode_dec);
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (is_op) begin
          if (bcnt_q == '0) op_d = key_op;
        end else if (is_exe) begin
          alu_a_d  = a_q;
          alu_b_d  = b_q;
          alu_op_d = op_q;
          start_d  = 1'b1;
          state_d  = S_WAIT;
        end else if (is_ce) begin
          b_d    = '0;
          bcnt_d = '0;
        end else if (is_clr) begin
          clear_all = 1'b1;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (is_digit) begin
          a_d     = digit_ext;
          acnt_d  = CW'(1);
          state_d = S_A;
        end else if (is_op) begin
          // A full count keeps the carried-over result from being appended to.
          a_d     = res_q;
          acnt_d  = FULL_CNT;
          op_d    = key_op;
          b_d     = '0;
          bcnt_d  = '0;
          state_d = S_B;
        end else if (is_ce || is_clr) begin
          clear_all = 1'b1;
        end
      end
      default: state_d = S_A;
    endcase

    if (clear_all) begin
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      res_d    = '0;
      acnt_d   = '0;
      bcnt_d   = '0;
      op_d     = '0;
      alu_a_d  = '0;
      alu_b_d  = '0;
      alu_op_d = '0;
    end

    case (state_d)
      S_A:     disp_d = a_d;
      S_B:     disp_d = (bcnt_d != '0) ? b_d : a_d;
      S_WAIT:  disp_d = b_d;
      default: disp_d = res_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      acnt_q   <= '0;
      bcnt_q   <= '0;
      op_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      start_q  <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      acnt_q   <= acnt_d;
      bcnt_q   <= bcnt_d;
      op_q     <= op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      start_q  <= start_d;
      disp_q   <= disp_d;
    end
  end

  assign alu_start     = start_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign display_value = disp_q;
  assign stage         = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: scoreboard of expected ALU requests plus
// per-scenario checks of stage and display_value.
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        press = 1'b0;
  logic [4:0]  val = '0;
  logic        mode_dec = 1'b0;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_start;
  logic [15:0] alu_a, alu_b, display_value;
  logic [2:0]  alu_op;
  logic [1:0]  stage;

  calc_ctrl #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .press(press), .val(val), .mode_dec(mode_dec),
    .alu_done(alu_done), .alu_result(alu_result), .alu_start(alu_start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .display_value(display_value), .stage(stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   exp_starts = 0;
  logic prev_start = 1'b0;

  // Scoreboard: every alu_start pops one expected request.
  always @(negedge clk) begin
    txn_t t;
    if (alu_start) begin
      start_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL start_unexpected: got alu_start=1 a=%h b=%h op=%0d, required no request", alu_a, alu_b, alu_op);
      end else begin
        t = exp_q.pop_front();
        $display("txn: alu_start a=%h b=%h op=%0d (expected a=%h b=%h op=%0d)", alu_a, alu_b, alu_op, t.a, t.b, t.op);
        if ({alu_a, alu_b, alu_op} !== {t.a, t.b, t.op}) begin
          bad++;
          $display("FAIL alu_request: got a=%h b=%h op=%0d, required a=%h b=%h op=%0d", alu_a, alu_b, alu_op, t.a, t.b, t.op);
        end
      end
      if (prev_start) begin
        bad++;
        $display("FAIL start_width: got alu_start high two cycles, required one");
      end
    end
    prev_start <= alu_start;
  end

  task automatic press_key(input logic [4:0] v);
    @(negedge clk);
    press = 1'b1;
    val   = v;
    @(negedge clk);
    press = 1'b0;
    val   = '0;
    $display("txn: press %h -> stage=%0d display=%h", v, stage, display_value);
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    txn_t t;
    t.a = a; t.b = b; t.op = op;
    exp_q.push_back(t);
    exp_starts++;
  endtask

  task automatic pulse_done(input logic [15:0] r);
    @(negedge clk);
    alu_done   = 1'b1;
    alu_result = r;
    @(negedge clk);
    alu_done = 1'b0;
    $display("txn: alu_done %h -> stage=%0d display=%h", r, stage, display_value);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({stage, display_value, alu_a, alu_b, alu_op, alu_start} !== '0) begin
      bad++;
      $display("FAIL reset_state: got stage=%0d disp=%h a=%h b=%h op=%0d start=%b, required all 0",
               stage, display_value, alu_a, alu_b, alu_op, alu_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_hex_entry;
    mode_dec = 1'b0;
    for (int i = 1; i <= 5; i++) press_key(5'(i));
    total++;
    if (display_value !== 16'h1234) begin
      bad++; $display("FAIL hex_entry: got %h required %h", display_value, 16'h1234);
    end
    press_key(5'h16);
    total++;
    if (display_value !== 16'h0000) begin
      bad++; $display("FAIL hex_ce: got %h required 0000", display_value);
    end
  endtask

  task automatic test_decimal_add;
    press_key(5'h17);
    mode_dec = 1'b1;
    press_key(5'h09);
    press_key(5'h09);
    total++;
    if (display_value !== 16'd99) begin
      bad++; $display("FAIL dec_a: got %0d required 99", display_value);
    end
    press_key(5'h10);
    press_key(5'h0B);
    total++;
    if (stage !== 2'd1 || display_value !== 16'd99) begin
      bad++; $display("FAIL dec_ignore_b: got stage=%0d disp=%0d required stage=1 disp=99", stage, display_value);
    end
    press_key(5'h01);
    push_exp(16'd99, 16'd1, 3'd0);
    press_key(5'h13);
    total++;
    if (alu_start !== 1'b1 || stage !== 2'd2 || display_value !== 16'd1) begin
      bad++; $display("FAIL dec_exe: got start=%b stage=%0d disp=%0d required start=1 stage=2 disp=1", alu_start, stage, display_value);
    end
    repeat (2) @(negedge clk);
    pulse_done(16'd100);
    total++;
    if (stage !== 2'd3 || display_value !== 16'd100) begin
      bad++; $display("FAIL dec_result: got stage=%0d disp=%0d required stage=3 disp=100", stage, display_value);
    end
    mode_dec = 1'b0;
  endtask

  task automatic test_op_chain;
    press_key(5'h17);
    press_key(5'h05);
    press_key(5'h10);
    press_key(5'h14);
    press_key(5'h03);
    push_exp(16'h5, 16'h3, 3'd1);
    press_key(5'h13);
    pulse_done(16'h2);
    press_key(5'h11);
    total++;
    if (stage !== 2'd1 || display_value !== 16'h2) begin
      bad++; $display("FAIL chain_carry: got stage=%0d disp=%h required stage=1 disp=0002", stage, display_value);
    end
    press_key(5'h04);
    push_exp(16'h2, 16'h4, 3'd2);
    press_key(5'h13);
    pulse_done(16'h8);
    total++;
    if (display_value !== 16'h8) begin
      bad++; $display("FAIL chain_result: got %h required 0008", display_value);
    end
    press_key(5'h07);
    press_key(5'h08);
    total++;
    if (stage !== 2'd0 || display_value !== 16'h78) begin
      bad++; $display("FAIL chain_new_a: got stage=%0d disp=%h required stage=0 disp=0078", stage, display_value);
    end
  endtask

  task automatic test_wait_immunity;
    press_key(5'h17);
    press_key(5'h01);
    press_key(5'h10);
    press_key(5'h02);
    push_exp(16'h1, 16'h2, 3'd0);
    press_key(5'h13);
    press_key(5'h17);
    press_key(5'h05);
    press_key(5'h13);
    press_key(5'h14);
    total++;
    if (stage !== 2'd2 || display_value !== 16'h2 || start_cnt !== exp_starts) begin
      bad++; $display("FAIL wait_immune: got stage=%0d disp=%h starts=%0d required stage=2 disp=0002 starts=%0d",
                      stage, display_value, start_cnt, exp_starts);
    end
    pulse_done(16'h3);
    total++;
    if (stage !== 2'd3 || display_value !== 16'h3) begin
      bad++; $display("FAIL wait_done: got stage=%0d disp=%h required stage=3 disp=0003", stage, display_value);
    end
    press_key(5'h17);
    pulse_done(16'h55);
    total++;
    if (stage !== 2'd0 || display_value !== 16'h0) begin
      bad++; $display("FAIL stray_done: got stage=%0d disp=%h required stage=0 disp=0000", stage, display_value);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] seq1 [3];
    logic [4:0] seq2 [3];
    seq1 = '{5'h0A, 5'h0B, 5'h0C};
    seq2 = '{5'h10, 5'h01, 5'h13};
    press_key(5'h17);
    @(negedge clk);
    foreach (seq1[i]) begin
      press = 1'b1; val = seq1[i];
      @(negedge clk);
    end
    press = 1'b0;
    total++;
    if (display_value !== 16'h0ABC) begin
      bad++; $display("FAIL b2b_digits: got %h required 0abc", display_value);
    end
    push_exp(16'h0ABC, 16'h1, 3'd0);
    foreach (seq2[i]) begin
      press = 1'b1; val = seq2[i];
      @(negedge clk);
    end
    press = 1'b0;
    // alu_done raised in the same cycle alu_start is high
    alu_done = 1'b1; alu_result = 16'h0ABD;
    @(negedge clk);
    alu_done = 1'b0;
    total++;
    if (stage !== 2'd3 || display_value !== 16'h0ABD) begin
      bad++; $display("FAIL b2b_fast_done: got stage=%0d disp=%h required stage=3 disp=0abd", stage, display_value);
    end
  endtask

  task automatic test_async_reset;
    press_key(5'h17);
    press_key(5'h01);
    press_key(5'h10);
    press_key(5'h02);
    push_exp(16'h1, 16'h2, 3'd0);
    press_key(5'h13);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({stage, display_value, alu_a, alu_b, alu_op, alu_start} !== '0) begin
      bad++; $display("FAIL async_reset: got stage=%0d disp=%h a=%h b=%h op=%0d start=%b, required all 0",
                      stage, display_value, alu_a, alu_b, alu_op, alu_start);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_done(16'h77);
    total++;
    if (stage !== 2'd0 || display_value !== 16'h0) begin
      bad++; $display("FAIL post_reset_done: got stage=%0d disp=%h required stage=0 disp=0000", stage, display_value);
    end
  endtask

  task automatic test_invalid;
    press_key(5'h17);
    press_key(5'h03);
    press_key(5'h1F);
    press_key(5'h18);
    mode_dec = 1'b1;
    press_key(5'h0A);
    mode_dec = 1'b0;
    total++;
    if (stage !== 2'd0 || display_value !== 16'h3) begin
      bad++; $display("FAIL invalid_sa: got stage=%0d disp=%h required stage=0 disp=0003", stage, display_value);
    end
    press_key(5'h10);
    press_key(5'h1F);
    press_key(5'h18);
    total++;
    if (stage !== 2'd1 || display_value !== 16'h3) begin
      bad++; $display("FAIL invalid_sb: got stage=%0d disp=%h required stage=1 disp=0003", stage, display_value);
    end
    press_key(5'h06);
    push_exp(16'h3, 16'h6, 3'd0);
    press_key(5'h13);
    press_key(5'h1F);
    press_key(5'h18);
    total++;
    if (stage !== 2'd2 || display_value !== 16'h6) begin
      bad++; $display("FAIL invalid_wait: got stage=%0d disp=%h required stage=2 disp=0006", stage, display_value);
    end
    pulse_done(16'h9);
    press_key(5'h1F);
    press_key(5'h18);
    total++;
    if (stage !== 2'd3 || display_value !== 16'h9) begin
      bad++; $display("FAIL invalid_res: got stage=%0d disp=%h required stage=3 disp=0009", stage, display_value);
    end
  endtask

  initial begin
    test_reset();
    test_hex_entry();
    test_decimal_add();
    test_op_chain();
    test_wait_immunity();
    test_back_to_back();
    test_async_reset();
    test_invalid();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || start_cnt != exp_starts) begin
      bad++; $display("FAIL scoreboard_drain: got pending=%0d starts=%0d required pending=0 starts=%0d",
                      exp_q.size(), start_cnt, exp_starts);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
